// File: rtl/pc_sequencer_pkg.sv
// Shared widths, reset PC and FSM state type for the fetch/execute PC sequencer.
package pc_sequencer_pkg;

  localparam int unsigned N       = 32;
  localparam int unsigned Pb      = 8;
  localparam int unsigned ImmBits = 6;

  localparam logic [Pb-1:0] PC_RESET_DEFAULT = '0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalted
  } pcseq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus: the sequencer is master, instruction memory is slave.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic          imem_req;
  logic [Pb-1:0] imem_addr;
  logic          imem_ack;
  logic [N-1:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational next-PC select: sequential increment, zero-extended immediate or register target.
module pc_sequencer_next_pc_sel
  import pc_sequencer_pkg::*;
(
  input  logic               jump_en,
  input  logic               imm_or_reg,
  input  logic [ImmBits-1:0] imm,
  input  logic [N-1:0]       qs,
  input  logic [Pb-1:0]      pc,
  output logic [Pb-1:0]      next_pc
);

  always_comb begin
    next_pc = pc + Pb'(1);
    if (jump_en) begin
      // Register target keeps only the low Pb bits of the operand.
      next_pc = imm_or_reg ? qs[Pb-1:0] : Pb'(imm);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer owning the PC. Optional link-register write port
// is enabled by defining PC_LINK_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [Pb-1:0] RESET_PC = PC_RESET_DEFAULT,
  parameter int unsigned   CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt,
  pc_sequencer_if.master     imem,
  output logic [N-1:0]       instr_q,
  output logic               instr_valid,
  input  logic               ctl_done,
  input  logic               jump_en,
  input  logic               imm_or_reg,
  input  logic [ImmBits-1:0] imm,
  input  logic [N-1:0]       qs,
  output logic [Pb-1:0]      pc,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
`ifdef PC_LINK_EN
  ,
  input  logic               link_req,
  output logic               link_wr,
  output logic [Pb-1:0]      link_addr
`endif
);

  pcseq_state_t     state_q, state_d;
  logic [Pb-1:0]    pc_q, pc_d;
  logic [N-1:0]     instr_reg_q, instr_reg_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Pb-1:0]    next_pc;

`ifdef PC_LINK_EN
  logic          link_wr_q, link_wr_d;
  logic [Pb-1:0] link_addr_q, link_addr_d;
`endif

  pc_sequencer_next_pc_sel u_next_pc_sel (
    .jump_en    (jump_en),
    .imm_or_reg (imm_or_reg),
    .imm        (imm),
    .qs         (qs),
    .pc         (pc_q),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_reg_d = instr_reg_q;
    valid_d     = valid_q;
    req_d       = req_q;
    halted_d    = halted_q;
    cnt_d       = cnt_q;
`ifdef PC_LINK_EN
    link_wr_d   = 1'b0;
    link_addr_d = link_addr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          req_d   = 1'b1;
        end
      end
      StFetch: begin
        // run is not consulted here: an issued fetch always completes.
        if (imem.imem_ack) begin
          instr_reg_d = imem.imem_rdata;
          valid_d     = 1'b1;
          req_d       = 1'b0;
          state_d     = StExec;
        end
      end
      StExec: begin
        if (ctl_done) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + CNT_W'(1);
          valid_d = 1'b0;
`ifdef PC_LINK_EN
          if (jump_en && link_req) begin
            link_wr_d   = 1'b1;
            link_addr_d = pc_q + Pb'(1);
          end
`endif
          if (halt) begin
            state_d  = StHalted;
            halted_d = 1'b1;
          end else begin
            state_d = StFetch;
            req_d   = 1'b1;
          end
        end
      end
      StHalted: begin
        req_d    = 1'b0;
        halted_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      instr_reg_q <= '0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_reg_q <= instr_reg_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef PC_LINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_wr_q   <= 1'b0;
      link_addr_q <= '0;
    end else begin
      link_wr_q   <= link_wr_d;
      link_addr_q <= link_addr_d;
    end
  end

  assign link_wr   = link_wr_q;
  assign link_addr = link_addr_q;
`endif

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_q        = instr_reg_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against an arithmetic PC/counter model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int PcMod = 1 << Pb;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               run = 1'b0;
  logic               halt = 1'b0;
  logic               ctl_done = 1'b0;
  logic               jump_en = 1'b0;
  logic               imm_or_reg = 1'b0;
  logic [ImmBits-1:0] imm = '0;
  logic [N-1:0]       qs = '0;
  logic               link_req = 1'b0;
  logic [N-1:0]       instr_q;
  logic               instr_valid;
  logic [Pb-1:0]      pc;
  logic               halted;
  logic [31:0]        retired_cnt;
`ifdef PC_LINK_EN
  logic               link_wr;
  logic [Pb-1:0]      link_addr;
`endif

  int total = 0;
  int passed = 0;
  int failed = 0;
  int model_pc = 0;
  int model_cnt = 0;
  logic [N-1:0] word;

  pc_sequencer_if bus ();

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .halt        (halt),
    .imem        (bus),
    .instr_q     (instr_q),
    .instr_valid (instr_valid),
    .ctl_done    (ctl_done),
    .jump_en     (jump_en),
    .imm_or_reg  (imm_or_reg),
    .imm         (imm),
    .qs          (qs),
    .pc          (pc),
    .halted      (halted),
    .retired_cnt (retired_cnt)
`ifdef PC_LINK_EN
    ,
    .link_req    (link_req),
    .link_wr     (link_wr),
    .link_addr   (link_addr)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT in FETCH; returns after the ack edge, DUT in EXEC.
  task automatic fetch(input int unsigned lat, output logic [N-1:0] w);
    check("fetch_req", bus.imem_req, 1);
    check("fetch_addr", bus.imem_addr, model_pc);
    for (int i = 1; i < int'(lat); i++) begin
      tick();
      check("req_hold", bus.imem_req, 1);
      check("addr_hold", bus.imem_addr, model_pc);
    end
    w = $urandom;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = w;
    tick();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = $urandom;
    check("instr_q", instr_q, w);
    check("instr_valid_set", instr_valid, 1);
    check("req_drop", bus.imem_req, 0);
`ifdef PC_LINK_EN
    check("link_wr_pulse_end", link_wr, 0);
`endif
  endtask

  task automatic exec(input int unsigned wait_cyc, input bit jmp, input bit sel,
                      input int unsigned im, input logic [31:0] q, input bit hlt, input bit lnk);
    int old;
    for (int i = 0; i < int'(wait_cyc); i++) begin
      tick();
      check("valid_hold", instr_valid, 1);
      check("pc_hold", pc, model_pc);
    end
    ctl_done = 1'b1;
    jump_en = jmp;
    imm_or_reg = sel;
    imm = ImmBits'(im);
    qs = q;
    halt = hlt;
    link_req = lnk;
    old = model_pc;
    if (!jmp) model_pc = (model_pc + 1) % PcMod;
    else if (sel) model_pc = int'(q % PcMod);
    else model_pc = int'(im);
    model_cnt++;
    tick();
    ctl_done = 1'b0;
    jump_en = 1'($urandom);
    imm = ImmBits'($urandom);
    qs = $urandom;
    halt = 1'($urandom);
    link_req = 1'($urandom);
    check("pc_commit", pc, model_pc);
    check("retired_cnt", retired_cnt, model_cnt);
    check("valid_clear", instr_valid, 0);
    check("req_after_done", bus.imem_req, !hlt);
    check("halted", halted, hlt);
`ifdef PC_LINK_EN
    check("link_wr", link_wr, jmp && lnk);
    if (jmp && lnk) check("link_addr", link_addr, (old + 1) % PcMod);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_req", bus.imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr_q, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    tick();
    check("idle_no_req", bus.imem_req, 0);
    run = 1'b1;
    tick();
    run = 1'b0;

    // Sequential flow 0,1,2 then 3,4 to reach pc=5.
    for (int i = 0; i < 5; i++) begin
      fetch(2, word);
      exec(1, 0, 0, 0, 0, 0, 0);
    end
    check("cnt_after_5", retired_cnt, 5);
    fetch(1, word);
    exec(0, 1, 0, 'h2A, 0, 0, 0);
    fetch(1, word);
    exec(2, 1, 0, 7, 0, 0, 0);
    fetch(3, word);
    exec(0, 1, 1, 0, 32'hFFFF_FF13, 0, 0);
    fetch(1, word);
    exec(0, 1, 1, 0, 32'h0000_00FF, 0, 0);
    fetch(2, word);
    exec(1, 0, 0, 0, 0, 0, 0);

    // ctl_done during FETCH is ignored.
    ctl_done = 1'b1;
    jump_en = 1'b1;
    imm = 6'd5;
    tick();
    ctl_done = 1'b0;
    check("done_in_fetch_pc", pc, model_pc);
    check("done_in_fetch_req", bus.imem_req, 1);
    check("done_in_fetch_cnt", retired_cnt, model_cnt);
    fetch(1, word);

    // imem_ack during EXEC is ignored.
    bus.imem_ack = 1'b1;
    bus.imem_rdata = ~word;
    tick();
    bus.imem_ack = 1'b0;
    check("ack_in_exec_instr", instr_q, word);
    check("ack_in_exec_valid", instr_valid, 1);
    check("ack_in_exec_req", bus.imem_req, 0);
    check("ack_in_exec_pc", pc, model_pc);
    exec(0, 1, 0, 4, 0, 0, 0);
    fetch(1, word);
    exec(0, 0, 0, 0, 0, 1, 0);

    // HALTED is sticky regardless of run/ack.
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack = 1'($urandom);
      tick();
      check("halt_req_low", bus.imem_req, 0);
      check("halt_stays", halted, 1);
    end
    check("halt_pc", pc, 5);
    run = 1'b0;
    bus.imem_ack = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_pc = 0;
    model_cnt = 0;
    check("rst2_pc", pc, 0);
    check("rst2_cnt", retired_cnt, 0);
    check("rst2_halted", halted, 0);
    run = 1'b1;
    tick();
    run = 1'b0;
    fetch(1, word);
    exec(0, 1, 0, 9, 0, 0, 0);
    fetch(2, word);
    exec(0, 1, 0, 3, 0, 0, 1);

    // Asynchronous reset mid-FETCH.
    check("pre_rst_req", bus.imem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", bus.imem_req, 0);
    check("async_rst_pc", pc, 0);
    rst = 1'b0;
    model_pc = 0;
    model_cnt = 0;
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;

    for (int i = 0; i < 60; i++) begin
      fetch($urandom_range(1, 3), word);
      exec($urandom_range(0, 2), $urandom_range(0, 2) == 0, 1'($urandom),
           $urandom_range(0, (1 << ImmBits) - 1), $urandom, 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/execute sequencer that owns the program counter.
- Issues instruction-memory requests, holds the fetched instruction for the decoder, and waits for the core's completion strobe.
- On completion, commits the next PC: either PC+1, or a jump target taken from the zero-extended immediate or from the register operand.
- Sits between instruction memory and the decode/execute stage; replaces the free-running PC register of the single-cycle path.

Parameters:
- RESET_PC, 0, PC value loaded on reset (Pb bits).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  leave IDLE and start fetching.
- halt  in  1  sampled with ctl_done; stop after the current instruction.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  Pb  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  N  instruction word.
- instr_q  out  N  latched instruction.
- instr_valid  out  1  instr_q valid, high throughout EXEC.
- ctl_done  in  1  core finished the current instruction.
- jump_en  in  1  take jump (sampled with ctl_done).
- imm_or_reg  in  1  0 selects Imm target, 1 selects Qs target.
- imm  in  ImmBits  immediate jump target.
- qs  in  N  register jump target.
- pc  out  Pb  architectural PC.
- halted  out  1  high in HALTED.
- retired_cnt  out  CNT_W  instructions committed.

Behaviour:
- Reset values (asynchronous): pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr_q=0, retired_cnt=0, halted=0.
- Reset asserted mid-fetch drops imem_req immediately.
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE:
  - run=1 -> FETCH; imem_req rises on the same edge.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_ack.
  - imem_ack=1 -> instr_q<=imem_rdata, instr_valid<=1, imem_req<=0, go EXEC.
  - Minimum fetch latency is 1 cycle after imem_req rises.
  - run deasserting during FETCH does not abort the fetch.
- EXEC:
  - Wait for ctl_done. On ctl_done, pc<=next_pc, retired_cnt+=1, instr_valid<=0.
  - halt=1 with ctl_done -> HALTED; otherwise -> FETCH with imem_req<=1.
  - Back-to-back throughput: ack to EXEC (1 cycle), done to FETCH (1 cycle).
- HALTED:
  - halted=1, imem_req=0; only reset leaves this state.
- next_pc:
  - jump_en=0: pc+1, modulo 2^Pb (pc=2^Pb-1 wraps to 0).
  - jump_en=1, imm_or_reg=0: imm zero-extended to Pb.
  - jump_en=1, imm_or_reg=1: qs[Pb-1:0] (upper bits discarded).
- Ignored inputs:
  - imem_ack outside FETCH is ignored.
  - ctl_done outside EXEC is ignored.
  - jump_en, imm_or_reg, imm, qs, halt are don't-care without ctl_done.
- retired_cnt wraps to 0 after all-ones.
- Combinational outputs: none; all outputs are registered, except imem_addr, which is a direct copy of pc.

Optional Feature:
- Macro PC_LINK_EN.
- When defined, adds ports link_req (in 1), link_wr (out 1), link_addr (out Pb).
  - On ctl_done with jump_en=1 and link_req=1: link_wr pulses for one cycle and link_addr = old pc+1 (registered, same edge as the pc update).
  - link_wr and link_addr reset to 0.
- When undefined, these ports do not exist and link_req semantics are absent.

Decomposition:
- the_pkg additions:
  - typedef enum pcseq_state_t {IDLE, FETCH, EXEC, HALTED}.
  - Constant PC_RESET_DEFAULT.
- Existing constants used: N, Pb, ImmBits.
- Sub-module next_pc_sel: combinational; inputs jump_en, imm_or_reg, imm, qs, pc; output next_pc (Pb). Instantiated once.

Test Plan:
- Reset with RESET_PC=0; run=1; ack each fetch after 2 cycles; 3 sequential completions -> imem_addr sequence 0,1,2,3; retired_cnt=3.
- In EXEC at pc=5: ctl_done, jump_en=1, imm_or_reg=0, imm=0x2A -> next imem_addr=0x2A.
- At pc=7: jump_en=1, imm_or_reg=1, qs=0xFFFF_FF13 -> pc=0x13 (Pb=8), upper bits discarded.
- pc=2^Pb-1, no jump -> pc=0; separately, imem_ack pulsed during EXEC and ctl_done pulsed during FETCH -> no state or pc change.
- halt=1 with ctl_done at pc=4 -> pc=5, halted=1, imem_req stays 0 for 20 cycles; assert rst mid-FETCH -> imem_req drops asynchronously, pc=RESET_PC.
- PC_LINK_EN defined: jump at pc=9 with link_req=1 to imm=3 -> link_wr one-cycle pulse, link_addr=10, pc=3.
